text_string_plotter: RTL and testbench
======================================

Name: text_string_plotter

Overview:
- Sequential string renderer for the game's HUD and title text.
- Holds a loadable string of character codes and walks each glyph cell in raster order, querying an external glyph LUT one pixel at a time.
- Emits framebuffer pixel writes over a valid/ready handshake.
- Adds what the single-glyph decoders lack: multi-character strings, pixel scaling (x1/x2), opaque/transparent background modes and back-pressure.

Parameters:
- MAX_CHARS, 16, string buffer depth (characters).
- CODE_W, 5, character code width.
- COORD_W, 8, screen coordinate width.
- COLOUR_W, 6, colour width.
- CELL_W, 8, glyph cell width in unscaled pixels.
- CELL_H, 10, glyph cell height in unscaled pixels.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  write one buffer entry this cycle.
- load_addr  in  clog2(MAX_CHARS)  buffer entry index.
- load_code  in  CODE_W  character code to store.
- start  in  1  begin rendering (accepted only in IDLE).
- origin_x  in  COORD_W  top-left x of first cell.
- origin_y  in  COORD_W  top-left y.
- length  in  clog2(MAX_CHARS)+1  characters to draw, 0..MAX_CHARS.
- scale2  in  1  0 = x1, 1 = each glyph pixel drawn as a 2x2 block.
- opaque  in  1  1 = also draw glyph-off pixels in bg_colour.
- fg_colour  in  COLOUR_W  glyph colour.
- bg_colour  in  COLOUR_W  background colour (opaque mode).
- glyph_code  out  CODE_W  code presented to the glyph LUT.
- glyph_col  out  COORD_W  cell-relative column, 0..CELL_W-1.
- glyph_row  out  COORD_W  cell-relative row, 0..CELL_H-1.
- glyph_on  in  1  combinational LUT answer for the current code/col/row.
- pix_x  out  COORD_W  pixel x.
- pix_y  out  COORD_W  pixel y.
- pix_colour  out  COLOUR_W  pixel colour.
- pix_valid  out  1  pixel presented.
- pix_ready  in  1  consumer accepts the pixel.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE; pix_valid=0, busy=0, done=0; pix_x/pix_y/pix_colour=0; glyph_code/col/row=0; all buffer entries cleared to code 0. Reset mid-render abandons the string immediately; no further pixels are emitted.
- Buffer:
  - load_en writes buffer[load_addr] in IDLE only.
  - Writes while busy are ignored.
  - Writes with load_addr >= MAX_CHARS are ignored.
- Start:
  - In IDLE, start=1 latches origin, length, scale2, opaque and both colours, and sets busy next cycle.
  - start is ignored while busy.
  - length > MAX_CHARS is clamped to MAX_CHARS.
- States:
  - IDLE -> (start, length>0) SCAN.
  - IDLE -> (start, length=0) DONE.
  - SCAN -> EMIT when the position produces a pixel; otherwise advance and stay in SCAN.
  - EMIT -> SCAN after the handshake, or -> DONE if it was the last position.
  - DONE -> IDLE.
  - done=1 for exactly the DONE cycle; busy drops in the same cycle.
- Scan order: character index (outer), row, column, sub-row sy, sub-column sx (inner). sy and sx run 0..1 when scale2=1, otherwise fixed at 0.
- Each SCAN cycle drives glyph_code=buffer[idx], glyph_col=col, glyph_row=row, and samples glyph_on in that same cycle.
- Pixel produced when glyph_on=1 (colour fg_colour), or when opaque=1 (colour bg_colour on glyph-off positions).
  - Transparent glyph-off positions cost one cycle each and emit nothing.
- Coordinates, with s = 1 or 2:
  - pix_x = origin_x + idx*CELL_W*s + col*s + sx
  - pix_y = origin_y + row*s + sy
  - Both computed modulo 2^COORD_W (wrap-around, no clipping).
- Handshake:
  - Outputs are registered: pix_valid rises the cycle after the SCAN hit.
  - pix_x, pix_y and pix_colour stay stable while pix_valid=1 and pix_ready=0.
  - The transfer completes on the cycle where pix_valid and pix_ready are both 1.
  - The scan stalls (no LUT advance) during EMIT.
  - Maximum throughput is one pixel per two cycles.
- Latency: first pixel appears 2 cycles after start when the first position hits.
- done is asserted the cycle after the final handshake, or the cycle after the final non-emitting SCAN position.

Test Plan:
- Load codes {3,7} at addr 0,1; start origin (10,20), length 2, scale2=0, opaque=0, LUT lights only col 2 of every row, pix_ready=1 -> exactly 20 pixels, x in {12,20}, y 20..29, colour fg; then one done pulse; busy low afterwards.
- Same setup with opaque=1 -> 160 pixels; 140 of them in bg_colour; first pixel (10,20) 2 cycles after start.
- scale2=1, length 1, LUT lit only at (col 0,row 0), origin (5,5) -> 4 pixels in order (5,5),(6,5),(5,6),(6,6).
- origin_x=250, length 1, opaque=1 -> x wraps 250..255 then 0..1; no pixel dropped.
- Hold pix_ready=0 for 10 cycles mid-string -> pix_x/pix_y/pix_colour/pix_valid stable; no pixel lost or duplicated.
- length=0 -> done the cycle after start, no pix_valid. Separately, assert reset mid-string -> pix_valid=0 and busy=0 next cycle, buffer reads code 0. Separately, load_en while busy -> buffer unchanged.

Source files
------------

// File: rtl/text_string_plotter.sv
// Sequential HUD/title string renderer: walks each glyph cell of a loaded string,
// queries an external glyph LUT per pixel and emits framebuffer writes over valid/ready.
module text_string_plotter #(
    parameter int MAX_CHARS = 16,
    parameter int CODE_W    = 5,
    parameter int COORD_W   = 8,
    parameter int COLOUR_W  = 6,
    parameter int CELL_W    = 8,
    parameter int CELL_H    = 10,
    localparam int AW       = $clog2(MAX_CHARS),
    localparam int LEN_W    = AW + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_en,
    input  logic [AW-1:0]       load_addr,
    input  logic [CODE_W-1:0]   load_code,
    input  logic                start,
    input  logic [COORD_W-1:0]  origin_x,
    input  logic [COORD_W-1:0]  origin_y,
    input  logic [LEN_W-1:0]    length,
    input  logic                scale2,
    input  logic                opaque,
    input  logic [COLOUR_W-1:0] fg_colour,
    input  logic [COLOUR_W-1:0] bg_colour,
    output logic [CODE_W-1:0]   glyph_code,
    output logic [COORD_W-1:0]  glyph_col,
    output logic [COORD_W-1:0]  glyph_row,
    input  logic                glyph_on,
    output logic [COORD_W-1:0]  pix_x,
    output logic [COORD_W-1:0]  pix_y,
    output logic [COLOUR_W-1:0] pix_colour,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_t;

    state_t               state_reg;
    logic [CODE_W-1:0]    buffer_reg [MAX_CHARS];

    logic [COORD_W-1:0]   ox_reg, oy_reg;
    logic [LEN_W-1:0]     len_reg;
    logic                 scale_reg, opaque_reg;
    logic [COLOUR_W-1:0]  fg_reg, bg_reg;

    logic [AW-1:0]        idx_reg, idx_next;
    logic [COORD_W-1:0]   col_reg, col_next;
    logic [COORD_W-1:0]   row_reg, row_next;
    logic                 sx_reg, sx_next;
    logic                 sy_reg, sy_next;
    logic                 last_reg;

    logic [COORD_W-1:0]   pix_x_reg, pix_y_reg;
    logic [COLOUR_W-1:0]  pix_colour_reg;
    logic                 pix_valid_reg, busy_reg, done_reg;

    logic [COORD_W-1:0]   cell_off, x_off, y_off, hit_x, hit_y;
    logic                 last_pos, hit;

    // String buffer: writable only while idle; out-of-range addresses dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_CHARS; i++) begin
                buffer_reg[i] <= '0;
            end
        end else if (load_en && state_reg == S_IDLE &&
                     {1'b0, load_addr} < LEN_W'(MAX_CHARS)) begin
            buffer_reg[load_addr] <= load_code;
        end
    end

    assign glyph_code = buffer_reg[idx_reg];
    assign glyph_col  = col_reg;
    assign glyph_row  = row_reg;

    // Scaling by two doubles the whole cell-relative offset before adding the sub-pixel.
    always_comb begin
        cell_off = COORD_W'(idx_reg) * COORD_W'(CELL_W) + col_reg;
        x_off    = scale_reg ? {cell_off[COORD_W-2:0], 1'b0} : cell_off;
        y_off    = scale_reg ? {row_reg[COORD_W-2:0], 1'b0} : row_reg;
        hit_x    = ox_reg + x_off + COORD_W'(sx_reg);
        hit_y    = oy_reg + y_off + COORD_W'(sy_reg);
    end

    assign hit      = glyph_on || opaque_reg;
    assign last_pos = (LEN_W'(idx_reg) + LEN_W'(1) == len_reg) &&
                      (row_reg == COORD_W'(CELL_H - 1)) &&
                      (col_reg == COORD_W'(CELL_W - 1)) &&
                      (sx_reg == scale_reg) && (sy_reg == scale_reg);

    // Raster order: idx, row, col, sy, sx (innermost); sub-pixels only count when scaled.
    always_comb begin
        sx_next  = sx_reg;
        sy_next  = sy_reg;
        col_next = col_reg;
        row_next = row_reg;
        idx_next = idx_reg;
        if (sx_reg != scale_reg) begin
            sx_next = 1'b1;
        end else begin
            sx_next = 1'b0;
            if (sy_reg != scale_reg) begin
                sy_next = 1'b1;
            end else begin
                sy_next = 1'b0;
                if (col_reg != COORD_W'(CELL_W - 1)) begin
                    col_next = col_reg + COORD_W'(1);
                end else begin
                    col_next = '0;
                    if (row_reg != COORD_W'(CELL_H - 1)) begin
                        row_next = row_reg + COORD_W'(1);
                    end else begin
                        row_next = '0;
                        idx_next = idx_reg + AW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            ox_reg         <= '0;
            oy_reg         <= '0;
            len_reg        <= '0;
            scale_reg      <= 1'b0;
            opaque_reg     <= 1'b0;
            fg_reg         <= '0;
            bg_reg         <= '0;
            idx_reg        <= '0;
            col_reg        <= '0;
            row_reg        <= '0;
            sx_reg         <= 1'b0;
            sy_reg         <= 1'b0;
            last_reg       <= 1'b0;
            pix_x_reg      <= '0;
            pix_y_reg      <= '0;
            pix_colour_reg <= '0;
            pix_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        ox_reg     <= origin_x;
                        oy_reg     <= origin_y;
                        len_reg    <= (length > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : length;
                        scale_reg  <= scale2;
                        opaque_reg <= opaque;
                        fg_reg     <= fg_colour;
                        bg_reg     <= bg_colour;
                        idx_reg    <= '0;
                        col_reg    <= '0;
                        row_reg    <= '0;
                        sx_reg     <= 1'b0;
                        sy_reg     <= 1'b0;
                        if (length == '0) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_SCAN;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (hit) begin
                        pix_x_reg      <= hit_x;
                        pix_y_reg      <= hit_y;
                        pix_colour_reg <= glyph_on ? fg_reg : bg_reg;
                        pix_valid_reg  <= 1'b1;
                        last_reg       <= last_pos;
                        state_reg      <= S_EMIT;
                    end else if (last_pos) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                    if (!last_pos) begin
                        idx_reg <= idx_next;
                        col_reg <= col_next;
                        row_reg <= row_next;
                        sx_reg  <= sx_next;
                        sy_reg  <= sy_next;
                    end
                end
                S_EMIT: begin
                    if (pix_ready) begin
                        pix_valid_reg <= 1'b0;
                        if (last_reg) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg <= S_SCAN;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign pix_x      = pix_x_reg;
    assign pix_y      = pix_y_reg;
    assign pix_colour = pix_colour_reg;
    assign pix_valid  = pix_valid_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_text_string_plotter.sv
// Directed bench for text_string_plotter: a small glyph LUT model plus a pixel collector.
module tb_text_string_plotter;

    logic       clk;
    logic       reset;
    logic       load_en;
    logic [3:0] load_addr;
    logic [4:0] load_code;
    logic       start;
    logic [7:0] origin_x, origin_y;
    logic [4:0] length;
    logic       scale2, opaque;
    logic [5:0] fg_colour, bg_colour;
    logic [4:0] glyph_code;
    logic [7:0] glyph_col, glyph_row;
    logic       glyph_on;
    logic [7:0] pix_x, pix_y;
    logic [5:0] pix_colour;
    logic       pix_valid, pix_ready, busy, done;

    int checks = 0;
    int errors = 0;
    int lut_mode = 0;

    int px [512];
    int py [512];
    int pc [512];
    int npix, done_cyc, first_cyc, stable_bad;

    localparam logic [5:0] FG = 6'h2A;
    localparam logic [5:0] BG = 6'h15;

    text_string_plotter dut (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_addr(load_addr), .load_code(load_code),
        .start(start), .origin_x(origin_x), .origin_y(origin_y), .length(length),
        .scale2(scale2), .opaque(opaque), .fg_colour(fg_colour), .bg_colour(bg_colour),
        .glyph_code(glyph_code), .glyph_col(glyph_col), .glyph_row(glyph_row),
        .glyph_on(glyph_on),
        .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode 0: column 2 lit for codes 3 and 7 only. Mode 1: only (col 0,row 0) lit.
    always_comb begin
        glyph_on = 1'b0;
        if (lut_mode == 0)
            glyph_on = (glyph_col == 8'd2) && (glyph_code == 5'd3 || glyph_code == 5'd7);
        else
            glyph_on = (glyph_col == 8'd0) && (glyph_row == 8'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] addr, input logic [4:0] code);
        load_addr = addr;
        load_code = code;
        load_en   = 1'b1;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic run_render(input logic [7:0] ox, input logic [7:0] oy, input logic [4:0] len,
                              input logic sc, input logic op);
        origin_x = ox;
        origin_y = oy;
        length   = len;
        scale2   = sc;
        opaque   = op;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Records each accepted pixel; optionally withholds ready for 10 cycles on pixel stall_at.
    task automatic collect(input int cyc0, input int stall_at, input int limit);
        int cyc;
        bit stalled;
        logic [7:0] sx_s, sy_s;
        logic [5:0] sc_s;
        cyc = cyc0; stalled = 0;
        npix = 0; done_cyc = -1; first_cyc = -1; stable_bad = 0;
        while (cyc < limit && done_cyc < 0) begin
            if (pix_valid && first_cyc < 0) first_cyc = cyc;
            if (pix_valid && !stalled && npix == stall_at) begin
                stalled = 1;
                pix_ready = 1'b0;
                sx_s = pix_x; sy_s = pix_y; sc_s = pix_colour;
                repeat (10) begin
                    tick();
                    cyc++;
                    if (pix_valid !== 1'b1 || pix_x !== sx_s || pix_y !== sy_s || pix_colour !== sc_s)
                        stable_bad++;
                end
                pix_ready = 1'b1;
            end
            if (pix_valid && pix_ready) begin
                if (npix < 512) begin
                    px[npix] = pix_x; py[npix] = pix_y; pc[npix] = pix_colour;
                end
                npix++;
            end
            if (done) done_cyc = cyc;
            else begin
                tick();
                cyc++;
            end
        end
        chk("done_seen", done_cyc >= 0, 1);
        tick();
        chk("done_one_cycle", done, 1'b0);
        chk("busy_after_done", busy, 1'b0);
    endtask

    task automatic check_two_char_transparent(input string tag);
        chk({tag, "_count"}, npix, 20);
        for (int i = 0; i < npix && i < 20; i++) begin
            chk($sformatf("%s_x%0d", tag, i), px[i], (i < 10) ? 12 : 20);
            chk($sformatf("%s_y%0d", tag, i), py[i], 20 + (i % 10));
            chk($sformatf("%s_c%0d", tag, i), pc[i], FG);
        end
    endtask

    initial begin
        int bgc;
        int ok;
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_code = '0; start = 1'b0;
        origin_x = '0; origin_y = '0; length = '0; scale2 = 1'b0; opaque = 1'b0;
        fg_colour = FG; bg_colour = BG; pix_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_valid", pix_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pix", {pix_x, pix_y, pix_colour}, 0);
        chk("rst_glyph", {glyph_code, glyph_col, glyph_row}, 0);

        load(4'd0, 5'd3);
        load(4'd1, 5'd7);

        // Transparent two-character string
        lut_mode = 0;
        run_render(8'd10, 8'd20, 5'd2, 1'b0, 1'b0);
        chk("t1_busy", busy, 1'b1);
        collect(1, -1, 1000);
        check_two_char_transparent("t1");
        chk("t1_done_cyc", done_cyc, 181);
        $display("t1 transparent: %0d pixels, done at cycle %0d", npix, done_cyc);

        // Opaque: every position emits
        run_render(8'd10, 8'd20, 5'd2, 1'b0, 1'b1);
        collect(1, -1, 1000);
        chk("t2_count", npix, 160);
        bgc = 0;
        for (int i = 0; i < npix && i < 512; i++) if (pc[i] == BG) bgc++;
        chk("t2_bg_count", bgc, 140);
        chk("t2_first_cyc", first_cyc, 2);
        chk("t2_p0", {px[0][7:0], py[0][7:0], pc[0][5:0]}, {8'd10, 8'd20, BG});
        chk("t2_p2", {px[2][7:0], py[2][7:0], pc[2][5:0]}, {8'd12, 8'd20, FG});
        chk("t2_p159", {px[159][7:0], py[159][7:0], pc[159][5:0]}, {8'd25, 8'd29, BG});
        chk("t2_done_cyc", done_cyc, 321);
        $display("t2 opaque: %0d pixels, %0d bg, done at cycle %0d", npix, bgc, done_cyc);

        // Scale x2, single lit glyph pixel -> 2x2 block
        lut_mode = 1;
        run_render(8'd5, 8'd5, 5'd1, 1'b1, 1'b0);
        collect(1, -1, 1000);
        chk("t3_count", npix, 4);
        chk("t3_p0", {px[0][7:0], py[0][7:0]}, {8'd5, 8'd5});
        chk("t3_p1", {px[1][7:0], py[1][7:0]}, {8'd6, 8'd5});
        chk("t3_p2", {px[2][7:0], py[2][7:0]}, {8'd5, 8'd6});
        chk("t3_p3", {px[3][7:0], py[3][7:0]}, {8'd6, 8'd6});
        chk("t3_done_cyc", done_cyc, 325);
        $display("t3 scale2: %0d pixels, done at cycle %0d", npix, done_cyc);

        // X wrap-around
        lut_mode = 0;
        run_render(8'd250, 8'd20, 5'd1, 1'b0, 1'b1);
        collect(1, -1, 1000);
        chk("t4_count", npix, 80);
        for (int i = 0; i < npix && i < 80; i++) begin
            chk($sformatf("t4_x%0d", i), px[i], (250 + (i % 8)) % 256);
            chk($sformatf("t4_y%0d", i), py[i], 20 + (i / 8));
        end
        $display("t4 wrap: %0d pixels, pixel 6 at x=%0d", npix, px[6]);

        // Back-pressure mid-string
        run_render(8'd10, 8'd20, 5'd2, 1'b0, 1'b0);
        collect(1, 5, 1000);
        chk("t5_stable", stable_bad, 0);
        check_two_char_transparent("t5");
        $display("t5 stall: %0d pixels, unstable cycles %0d", npix, stable_bad);

        // Length above MAX_CHARS clamps to 16 (entries 2..15 hold code 0)
        run_render(8'd10, 8'd20, 5'd20, 1'b0, 1'b0);
        collect(1, -1, 2000);
        chk("t6_count", npix, 20);
        chk("t6_done_cyc", done_cyc, 1301);
        $display("t6 clamp: %0d pixels, done at cycle %0d", npix, done_cyc);

        // Zero length
        run_render(8'd10, 8'd20, 5'd0, 1'b0, 1'b1);
        chk("t7_done", done, 1'b1);
        chk("t7_busy", busy, 1'b0);
        chk("t7_valid", pix_valid, 1'b0);
        tick();
        chk("t7_done_low", done, 1'b0);
        $display("t7 zero length: done pulse checked");

        // Load while busy must not change the buffer
        run_render(8'd10, 8'd20, 5'd2, 1'b0, 1'b0);
        chk("t8_busy", busy, 1'b1);
        load(4'd0, 5'd9);
        collect(2, -1, 1000);
        check_two_char_transparent("t8");
        $display("t8 load while busy: %0d pixels", npix);

        // Reset mid-string
        run_render(8'd10, 8'd20, 5'd2, 1'b0, 1'b1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t9_valid", pix_valid, 1'b0);
        chk("t9_busy", busy, 1'b0);
        chk("t9_code", glyph_code, 5'd0);
        ok = 1;
        repeat (5) begin
            tick();
            if (pix_valid !== 1'b0) ok = 0;
        end
        chk("t9_quiet", ok, 1);
        run_render(8'd10, 8'd20, 5'd2, 1'b0, 1'b0);
        collect(1, -1, 1000);
        chk("t9_cleared_count", npix, 0);
        chk("t9_done_cyc", done_cyc, 161);
        $display("t9 reset mid-string: %0d pixels after reset", npix);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
